// File: rtl/sop_sweep_eval_pkg.sv
// Shared types and constants for the sum-of-products sweep evaluator.
// Holds the sweep FSM state type, legal input-count range and the
// truth-table width helper used to size every table port.
package sop_pkg;

  localparam int N_IN_MIN = 2;
  localparam int N_IN_MAX = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sweep_state_e;

  // One truth-table bit per minterm of an n-input function.
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/sop_sweep_eval_tt_reg.sv
// Truth-table register: holds f() as a 2^N_IN-bit mask, bit k = f(minterm k).
// Latency: a load accepted at an edge is visible on both read ports right after it.
// Backpressure: load is written only when load_vld && load_rdy; otherwise dropped.
module sop_tt_reg
  import sop_pkg::*;
#(
  parameter int N_IN = 4,
  localparam int TT_W = tt_width(N_IN)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            load_vld,
  input  logic            load_rdy,
  input  logic [TT_W-1:0] load_dat,
  input  logic [N_IN-1:0] eval_idx,
  output logic            eval_bit,
  input  logic [N_IN-1:0] sweep_idx,
  output logic            sweep_bit
);

  logic [TT_W-1:0] tt_q;
  logic [TT_W-1:0] tt_d;

  // Next table value: replace the whole mask on an accepted load.
  always_comb begin
    tt_d = tt_q;
    if (load_vld && load_rdy) begin
      tt_d = load_dat;
    end
  end

  // Table storage; reset clears the function to constant 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tt_q <= '0;
    end else begin
      tt_q <= tt_d;
    end
  end

  // Two independent read ports into the same storage.
  assign eval_bit  = tt_q[eval_idx];
  assign sweep_bit = tt_q[sweep_idx];

endmodule

// File: rtl/sop_sweep_eval.sv
// Programmable N-input SOP evaluator with registered eval path and exhaustive sweep engine.
// Latency: OUT one cycle after IN; sweep emits 2^N_IN back-to-back samples after start edge.
// Backpressure: loads and starts are ignored while a sweep runs (LOAD_READY low). Optional
// self-check (EXP_MASK / MISMATCH_CNT / MISMATCH_OK) built when SOP_SWEEP_CHECK_EN is defined.
module sop_sweep_eval
  import sop_pkg::*;
#(
  parameter int N_IN = 4,
  localparam int TT_W = tt_width(N_IN)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            LOAD_VALID,
  input  logic [TT_W-1:0] LOAD_DATA,
  output logic            LOAD_READY,
  input  logic [N_IN-1:0] IN,
  output logic            OUT,
  input  logic            SWEEP_START,
  output logic            SWEEP_BUSY,
  output logic            SWEEP_VALID,
  output logic [N_IN-1:0] SWEEP_IDX,
  output logic            SWEEP_OUT,
  output logic            SWEEP_DONE,
  output logic [N_IN:0]   ONES_COUNT
`ifdef SOP_SWEEP_CHECK_EN
  ,
  input  logic [TT_W-1:0] EXP_MASK,
  output logic [N_IN:0]   MISMATCH_CNT,
  output logic            MISMATCH_OK
`endif
);

  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("sop_sweep_eval: N_IN out of range");
  end

  localparam logic [N_IN-1:0] IDX_LAST = '1;
  localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE  = (N_IN+1)'(1);

  sweep_state_e    state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic            vld_q, vld_d;
  logic            done_q, done_d;
  logic [N_IN-1:0] sidx_q, sidx_d;
  logic            sout_q, sout_d;
  logic            out_q, out_d;
  logic            eval_bit;
  logic            sweep_bit;
  logic            load_rdy;

  // A sweep in flight owns the table, so loads are refused until it finishes.
  assign load_rdy = (state_q == IDLE);

  sop_tt_reg #(.N_IN(N_IN)) u_tt (
    .CLK       (CLK),
    .RST       (RST),
    .load_vld  (LOAD_VALID),
    .load_rdy  (load_rdy),
    .load_dat  (LOAD_DATA),
    .eval_idx  (IN),
    .eval_bit  (eval_bit),
    .sweep_idx (idx_q),
    .sweep_bit (sweep_bit)
  );

`ifdef SOP_SWEEP_CHECK_EN
  logic [TT_W-1:0] exp_q, exp_d;
  logic [N_IN:0]   mism_q, mism_d;
`endif

  // Next-state for evaluation register and sweep engine.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ones_d  = ones_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    sidx_d  = sidx_q;
    sout_d  = sout_q;
    out_d   = eval_bit;
`ifdef SOP_SWEEP_CHECK_EN
    exp_d   = exp_q;
    mism_d  = mism_q;
`endif
    case (state_q)
      IDLE: begin
        if (SWEEP_START) begin
          state_d = RUN;
          idx_d   = '0;
          ones_d  = '0;
`ifdef SOP_SWEEP_CHECK_EN
          exp_d   = EXP_MASK;
          mism_d  = '0;
`endif
        end
      end
      RUN: begin
        vld_d  = 1'b1;
        sidx_d = idx_q;
        sout_d = sweep_bit;
        ones_d = ones_q + {{N_IN{1'b0}}, sweep_bit};
        // Wraps to 0 after the last minterm; not looked at again until restart.
        idx_d  = idx_q + IDX_ONE;
`ifdef SOP_SWEEP_CHECK_EN
        if (sweep_bit != exp_q[idx_q]) begin
          mism_d = mism_q + CNT_ONE;
        end
`endif
        if (idx_q == IDX_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state, including the FSM, updates here with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ones_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      sidx_q  <= '0;
      sout_q  <= 1'b0;
      out_q   <= 1'b0;
`ifdef SOP_SWEEP_CHECK_EN
      exp_q   <= '0;
      mism_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      sidx_q  <= sidx_d;
      sout_q  <= sout_d;
      out_q   <= out_d;
`ifdef SOP_SWEEP_CHECK_EN
      exp_q   <= exp_d;
      mism_q  <= mism_d;
`endif
    end
  end

  assign LOAD_READY  = load_rdy;
  assign OUT         = out_q;
  assign SWEEP_BUSY  = (state_q == RUN);
  assign SWEEP_VALID = vld_q;
  assign SWEEP_IDX   = sidx_q;
  assign SWEEP_OUT   = sout_q;
  assign SWEEP_DONE  = done_q;
  assign ONES_COUNT  = ones_q;
`ifdef SOP_SWEEP_CHECK_EN
  assign MISMATCH_CNT = mism_q;
  assign MISMATCH_OK  = (state_q == IDLE) && (mism_q == '0);
`endif

endmodule

// File: tb/tb_sop_sweep_eval.sv
// Directed bench for sop_sweep_eval (N_IN = 4): eval vector table plus sweep sequences.
module tb_sop_sweep_eval;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LOAD_VALID = 1'b0;
  logic [15:0] LOAD_DATA = '0;
  logic        LOAD_READY;
  logic [3:0]  IN = '0;
  logic        OUT;
  logic        SWEEP_START = 1'b0;
  logic        SWEEP_BUSY;
  logic        SWEEP_VALID;
  logic [3:0]  SWEEP_IDX;
  logic        SWEEP_OUT;
  logic        SWEEP_DONE;
  logic [4:0]  ONES_COUNT;
`ifdef SOP_SWEEP_CHECK_EN
  logic [15:0] EXP_MASK = 16'h1062;
  logic [4:0]  MISMATCH_CNT;
  logic        MISMATCH_OK;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  sop_sweep_eval #(.N_IN(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .LOAD_VALID  (LOAD_VALID),
    .LOAD_DATA   (LOAD_DATA),
    .LOAD_READY  (LOAD_READY),
    .IN          (IN),
    .OUT         (OUT),
    .SWEEP_START (SWEEP_START),
    .SWEEP_BUSY  (SWEEP_BUSY),
    .SWEEP_VALID (SWEEP_VALID),
    .SWEEP_IDX   (SWEEP_IDX),
    .SWEEP_OUT   (SWEEP_OUT),
    .SWEEP_DONE  (SWEEP_DONE),
    .ONES_COUNT  (ONES_COUNT)
`ifdef SOP_SWEEP_CHECK_EN
    ,
    .EXP_MASK     (EXP_MASK),
    .MISMATCH_CNT (MISMATCH_CNT),
    .MISMATCH_OK  (MISMATCH_OK)
`endif
  );

  typedef struct {
    logic [3:0] in_v;
    logic       exp_out;
  } eval_vec_t;

  eval_vec_t vecs[8];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] d);
    LOAD_VALID = 1'b1;
    LOAD_DATA  = d;
    tick();
    LOAD_VALID = 1'b0;
  endtask

  // inj_kind 1: load FFFF + restart held for two cycles from sample inj_at.
  // inj_kind 2: reset asserted after sample inj_at, sweep abandoned.
  task automatic do_sweep(input logic [15:0] mask, input bit load_with_start,
                          input int inj_at, input int inj_kind);
    logic [15:0] exp_cap;
    exp_cap = '0;
`ifdef SOP_SWEEP_CHECK_EN
    exp_cap = EXP_MASK;
`endif
    SWEEP_START = 1'b1;
    if (load_with_start) begin
      LOAD_VALID = 1'b1;
      LOAD_DATA  = mask;
    end
    tick();
    SWEEP_START = 1'b0;
    LOAD_VALID  = 1'b0;
    check("start_busy", SWEEP_BUSY, 1);
    check("start_vld", SWEEP_VALID, 0);
    check("start_rdy", LOAD_READY, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("sw_vld[%0d]", i), SWEEP_VALID, 1);
      check($sformatf("sw_idx[%0d]", i), SWEEP_IDX, i);
      check($sformatf("sw_out[%0d]", i), SWEEP_OUT, mask[i]);
      check($sformatf("sw_done[%0d]", i), SWEEP_DONE, (i == 15));
      check($sformatf("sw_busy[%0d]", i), SWEEP_BUSY, (i != 15));
      if (inj_kind == 1 && i == inj_at) begin
        LOAD_VALID  = 1'b1;
        LOAD_DATA   = 16'hFFFF;
        SWEEP_START = 1'b1;
        #1;
        check("mid_rdy", LOAD_READY, 0);
      end
      if (inj_kind == 1 && i == inj_at + 2) begin
        LOAD_VALID  = 1'b0;
        SWEEP_START = 1'b0;
      end
      if (inj_kind == 2 && i == inj_at) begin
        RST = 1'b1;
        tick();
        check("rst_busy", SWEEP_BUSY, 0);
        check("rst_vld", SWEEP_VALID, 0);
        check("rst_ones", ONES_COUNT, 0);
        check("rst_out", OUT, 0);
        check("rst_idx", SWEEP_IDX, 0);
        check("rst_rdy", LOAD_READY, 1);
        RST = 1'b0;
        return;
      end
    end
    check("sw_ones", ONES_COUNT, $countones(mask));
    tick();
    check("end_vld", SWEEP_VALID, 0);
    check("end_done", SWEEP_DONE, 0);
    check("end_busy", SWEEP_BUSY, 0);
    check("end_rdy", LOAD_READY, 1);
    check("end_ones_hold", ONES_COUNT, $countones(mask));
`ifdef SOP_SWEEP_CHECK_EN
    check("mism_cnt", MISMATCH_CNT, $countones(mask ^ exp_cap));
    check("mism_ok", MISMATCH_OK, ($countones(mask ^ exp_cap) == 0));
`endif
  endtask

  initial begin
    logic prev;
    vecs[0] = '{4'b0000, 1'b0};
    vecs[1] = '{4'b0101, 1'b1};
    vecs[2] = '{4'b0110, 1'b1};
    vecs[3] = '{4'b1100, 1'b1};
    vecs[4] = '{4'b0001, 1'b1};
    vecs[5] = '{4'b1111, 1'b0};
    vecs[6] = '{4'b0010, 1'b0};
    vecs[7] = '{4'b1101, 1'b0};

    // Reset values.
    RST = 1'b1;
    tick();
    tick();
    check("rv_out", OUT, 0);
    check("rv_busy", SWEEP_BUSY, 0);
    check("rv_vld", SWEEP_VALID, 0);
    check("rv_idx", SWEEP_IDX, 0);
    check("rv_sout", SWEEP_OUT, 0);
    check("rv_done", SWEEP_DONE, 0);
    check("rv_ones", ONES_COUNT, 0);
    check("rv_rdy", LOAD_READY, 1);
    RST = 1'b0;

    // Load at edge k: OUT at k still from old (zero) table, new table from k+1.
    IN = 4'b0001;
    load(16'h1062);
    check("load_lat0", OUT, 0);
    tick();
    check("load_lat1", OUT, 1);

    // Evaluation table: OUT must not move before the edge, then show f(IN).
    prev = 1'b1;
    for (int i = 0; i < 8; i++) begin
      IN = vecs[i].in_v;
      #1;
      check($sformatf("eval_hold[%0d]", i), OUT, prev);
      tick();
      check($sformatf("eval[%0d]", i), OUT, vecs[i].exp_out);
      prev = vecs[i].exp_out;
    end

    IN = 4'b0000;
    do_sweep(16'h1062, 1'b0, -1, 0);
    load(16'hFFFF);
    do_sweep(16'hFFFF, 1'b0, -1, 0);
    load(16'h0000);
    do_sweep(16'h0000, 1'b0, -1, 0);

    // Load and restart attempts during a sweep are ignored.
    load(16'h1062);
    do_sweep(16'h1062, 1'b0, 3, 1);
    tick();
    check("mid_no_restart", SWEEP_BUSY, 0);

    // Load and start on the same edge: sweep sees the new table.
    do_sweep(16'h8001, 1'b1, -1, 0);

    // Reset mid-sweep clears everything including the table.
    load(16'h1062);
    IN = 4'b0001;
    tick();
    check("pre_rst_out", OUT, 1);
    do_sweep(16'h1062, 1'b0, 7, 2);
    do_sweep(16'h0000, 1'b0, -1, 0);

`ifdef SOP_SWEEP_CHECK_EN
    load(16'h1062);
    EXP_MASK = 16'h1063;
    do_sweep(16'h1062, 1'b0, -1, 0);
    EXP_MASK = 16'h1062;
    do_sweep(16'h1062, 1'b0, -1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sop_sweep_eval.md
Name: sop_sweep_eval

Overview:
Parametrised, programmable sum-of-products evaluator. It generalises the fixed 4-input SOP lab block to N inputs, with the function held as a loadable truth-table mask. It provides a registered evaluation path and a built-in exhaustive sweep engine that walks all 2^N minterms and counts true outputs. It sits beside lab SOP blocks as a reusable function-under-test and self-check source.

Parameters:
N_IN, 4, number of Boolean inputs; legal range 2..8
TT_W, 2**N_IN, truth-table width; localparam derived from N_IN, not overridable

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous reset, active-high
LOAD_VALID  input  1  truth-table load request
LOAD_DATA  input  TT_W  truth-table mask; bit k = f(minterm k)
LOAD_READY  output  1  load may be accepted this cycle
IN  input  N_IN  evaluation inputs; IN[N_IN-1] is MSB (A for N_IN=4)
OUT  output  1  registered f(IN)
SWEEP_START  input  1  start exhaustive sweep
SWEEP_BUSY  output  1  sweep in progress
SWEEP_VALID  output  1  SWEEP_IDX/SWEEP_OUT valid this cycle
SWEEP_IDX  output  N_IN  minterm index of current sweep sample
SWEEP_OUT  output  1  f(SWEEP_IDX)
SWEEP_DONE  output  1  one-cycle pulse on final sweep sample
ONES_COUNT  output  N_IN+1  number of true minterms seen in the sweep

Behaviour:
- Clocking: one clock (CLK); reset is synchronous and active-high (RST). Everything updates on the rising CLK edge.
- Reset values: truth table 0, OUT 0, SWEEP_BUSY 0, SWEEP_VALID 0, SWEEP_IDX 0, SWEEP_OUT 0, SWEEP_DONE 0, ONES_COUNT 0, FSM in IDLE.
- LOAD_READY equals !SWEEP_BUSY, combinationally from state.
- Load:
  - A load is accepted on an edge where LOAD_VALID && LOAD_READY; the table is written at that edge.
  - A load is ignored while busy. Nothing is queued.
- Evaluation:
  - OUT <= table[IN] every cycle, so latency is 1 cycle.
  - A load accepted at edge k affects OUT from edge k+1.
  - Evaluation continues during a sweep.
- FSM states: IDLE and RUN.
  - IDLE to RUN when SWEEP_START=1 at an edge. At that edge: idx counter <= 0, ONES_COUNT <= 0, SWEEP_BUSY <= 1.
  - RUN, each edge: SWEEP_VALID <= 1, SWEEP_IDX <= idx, SWEEP_OUT <= table[idx], ONES_COUNT += table[idx], idx++.
  - RUN ends on the edge that emits idx = TT_W-1. That edge also sets SWEEP_DONE <= 1 and the FSM goes to IDLE with SWEEP_BUSY <= 0.
  - SWEEP_DONE is therefore coincident with the last SWEEP_VALID. Both drop one cycle later.
- Sweep timing:
  - A sweep takes exactly TT_W valid cycles, with no gaps.
  - ONES_COUNT holds its final value until the next accepted start or reset.
- Boundary conditions:
  - SWEEP_START while RUN is ignored.
  - SWEEP_START and LOAD_VALID together in IDLE: the load is accepted and the sweep starts in the same edge. The sweep uses the new table.
  - All-ones table gives ONES_COUNT = TT_W, which needs the N_IN+1-bit width. The idx counter wraps internally and is unused after the end.
  - RST mid-sweep: return to IDLE and apply all reset values, including clearing the table.

Optional Feature:
- Macro: SOP_SWEEP_CHECK_EN.
- When defined:
  - Extra ports: EXP_MASK input TT_W, and MISMATCH_CNT output N_IN+1 (reset 0).
  - EXP_MASK is captured at sweep start.
  - For each sweep sample, MISMATCH_CNT increments when SWEEP_OUT differs from the captured bit. It clears at sweep start.
  - MISMATCH_OK output is 1 when in IDLE and MISMATCH_CNT == 0.
- When undefined: those ports and that logic are absent. Core behaviour is identical.

Decomposition:
- Package sop_pkg holds:
  - FSM state typedef (IDLE, RUN).
  - Function tt_width(n) returning 2**n.
  - Constants N_IN_MIN = 2 and N_IN_MAX = 8.
- Sub-module sop_tt_reg: truth-table register with load handshake and a read port indexed by IN, used for the evaluation path. The sweep path indexes the same storage.

Test Plan:
- Reset, then load 16'h1062 (minterms 1, 5, 6, 12). Drive IN = 0000, 0101, 0110, 1100 -> OUT = 0, 1, 1, 1, each one cycle after the input is applied.
- With 16'h1062 loaded, pulse SWEEP_START -> 16 consecutive SWEEP_VALID cycles, SWEEP_IDX 0..15. SWEEP_OUT high only at 1, 5, 6, 12. SWEEP_DONE at idx 15. ONES_COUNT = 4.
- Load 16'hFFFF, then sweep -> ONES_COUNT = 16. Load 16'h0000, then sweep -> ONES_COUNT = 0.
- Mid-sweep, drive LOAD_VALID with 16'hFFFF and SWEEP_START again -> LOAD_READY = 0, both ignored. The sweep completes with ONES_COUNT = 4.
- Assert RST at sweep idx 7 -> the next cycle shows BUSY 0, VALID 0, ONES_COUNT 0, OUT 0. A new sweep gives ONES_COUNT = 0.
- With SOP_SWEEP_CHECK_EN defined: table 16'h1062 and EXP_MASK 16'h1063 -> MISMATCH_CNT = 1 and MISMATCH_OK = 0. With EXP_MASK 16'h1062 -> MISMATCH_CNT = 0 and MISMATCH_OK = 1.
